// File: rtl/alu_trace_pkg.sv
// Shared types and constants for the ALU trace recorder: the captured
// vector layout, the byte-stream geometry and the dump FSM states.
package alu_trace_pkg;

   localparam int VEC_W         = 102;
   localparam int BYTES_PER_VEC = 13;
   localparam int SHIFT_W       = BYTES_PER_VEC * 8;

   // Field order matches the host test-vector file, MSB first.
   typedef struct packed {
      logic        zero;
      logic [4:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
   } trace_vec_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND
   } state_t;

   // Pads a 102-bit vector to a whole number of bytes; the two spare
   // bits sit above the zero flag so byte 0 reads {2'b00,zero,f}.
   function automatic logic [SHIFT_W-1:0] pad_vec(input trace_vec_t v);
      return {2'b00, v};
   endfunction

endpackage

// File: rtl/alu_trace_ram.sv
// Capture buffer storage: one write port and one registered read port.
// The array has no reset so it maps onto block RAM.
module alu_trace_ram
   import alu_trace_pkg::*;
#(
   parameter int DEPTH = 64,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [VEC_W-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [VEC_W-1:0] rd_data
);

   logic [VEC_W-1:0] mem [DEPTH];

   // Write a captured vector and register the requested read word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/alu_trace_recorder.sv
// Records ALU transactions into a circular buffer while idle, then streams
// each entry out as 13 bytes (MSB first) over a valid/ready byte link.
module alu_trace_recorder
   import alu_trace_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cap_en,
   input  logic [4:0]               alu_f,
   input  logic [31:0]              alu_a,
   input  logic [31:0]              alu_b,
   input  logic [31:0]              alu_y,
   input  logic                     alu_zero,
   input  logic                     dump_start,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic                     busy,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
   localparam logic [3:0]    LAST_BYTE  = 4'(BYTES_PER_VEC - 1);

   state_t state;
   state_t state_next;

   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [SHIFT_W-1:0] shift_reg;
   logic [3:0]         byte_cnt;
   logic               bypass_valid;
   trace_vec_t         bypass_data;

   trace_vec_t         cap_vec;
   logic [VEC_W-1:0]   ram_rd_data;
   trace_vec_t         load_vec;
   logic [AW-1:0]      rd_addr;

   logic cap_write;
   logic cap_drop;
   logic start_dump;
   logic xfer;
   logic last_byte;
   logic last_entry;
   logic rd_issue;

   assign cap_vec = {alu_zero, alu_f, alu_a, alu_b, alu_y};

   // Decode the events that drive both the FSM and the datapath.
   always_comb begin
      cap_write  = (state == IDLE) && cap_en && (count < FULL_COUNT);
      cap_drop   = cap_en && ((state != IDLE) || (count == FULL_COUNT));
      start_dump = (state == IDLE) && dump_start && ((count != '0) || cap_write);
      xfer       = (state == SEND) && tx_valid && tx_ready;
      last_byte  = xfer && (byte_cnt == LAST_BYTE);
      last_entry = last_byte && (count == ONE_COUNT);
      rd_issue   = start_dump || (last_byte && !last_entry);
      rd_addr    = (state == SEND) ? (rd_ptr + AW'(1)) : rd_ptr;
   end

   // A vector written in the same cycle a dump starts from an empty buffer
   // is read back through the bypass register, since the RAM read of that
   // address happens on the same edge as its write.
   assign load_vec = bypass_valid ? bypass_data : trace_vec_t'(ram_rd_data);

   alu_trace_ram #(
      .DEPTH(DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (cap_write),
      .wr_addr (wr_ptr),
      .wr_data (cap_vec),
      .rd_en   (rd_issue),
      .rd_addr (rd_addr),
      .rd_data (ram_rd_data)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: IDLE waits for a dump, LOAD is the RAM read bubble,
   // SEND streams 13 bytes and then fetches the next entry or finishes.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_dump) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            state_next = SEND;
         end
         SEND: begin
            if (last_byte) begin
               state_next = last_entry ? IDLE : LOAD;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Pointers, occupancy, overflow flag, shift register and byte counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow     <= 1'b0;
         shift_reg    <= '0;
         byte_cnt     <= '0;
         tx_valid     <= 1'b0;
         bypass_valid <= 1'b0;
         bypass_data  <= '0;
      end else begin
         bypass_valid <= start_dump && cap_write && (count == '0);
         if (cap_write) begin
            bypass_data <= cap_vec;
            wr_ptr      <= wr_ptr + AW'(1);
            count       <= count + ONE_COUNT;
         end

         if (cap_drop) begin
            overflow <= 1'b1;
         end else if (last_entry) begin
            overflow <= 1'b0;
         end

         case (state)
            LOAD: begin
               shift_reg <= pad_vec(load_vec);
               byte_cnt  <= '0;
               tx_valid  <= 1'b1;
            end
            SEND: begin
               if (xfer) begin
                  if (byte_cnt == LAST_BYTE) begin
                     tx_valid <= 1'b0;
                     rd_ptr   <= rd_ptr + AW'(1);
                     count    <= count - ONE_COUNT;
                     if (last_entry) begin
                        wr_ptr <= rd_ptr + AW'(1);
                     end
                  end else begin
                     shift_reg <= {shift_reg[SHIFT_W-9:0], 8'h00};
                     byte_cnt  <= byte_cnt + 4'd1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign tx_data = shift_reg[SHIFT_W-1 -: 8];
   assign busy    = (state != IDLE);

endmodule
